// File: rtl/sram_1rw1r_param.sv
// Two-port (1RW + 1R) SRAM simulation model with pipelined reads and collision flag.
// Define SRAM_WMASK_EN to add the WMASK0 byte-write-enable port.
module sram_1rw1r_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int RAM_DEPTH    = 1 << ADDR_WIDTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    RSTb,
    input  logic                    CSb0,
    input  logic                    WEb0,
    input  logic [ADDR_WIDTH-1:0]   ADDR0,
    input  logic [DATA_WIDTH-1:0]   DIN0,
`ifdef SRAM_WMASK_EN
    input  logic [DATA_WIDTH/8-1:0] WMASK0,
`endif
    output logic [DATA_WIDTH-1:0]   DOUT0,
    output logic                    VALID0,
    input  logic                    CSb1,
    input  logic [ADDR_WIDTH-1:0]   ADDR1,
    output logic [DATA_WIDTH-1:0]   DOUT1,
    output logic                    VALID1,
    output logic                    COLLISION
);

    localparam int L = READ_LATENCY;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);

    if (L != 1 && L != 2) begin : g_bad_latency
        $fatal(1, "sram_1rw1r_param: READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % 8 != 0 || RAM_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_geom
        $fatal(1, "sram_1rw1r_param: illegal DATA_WIDTH or RAM_DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

    logic                  in0, in1, rd0, rd1, wr0, col;
    logic [DATA_WIDTH-1:0] rdata0, rdata1, wdata, bitmask;

    always_comb begin
        in0 = {1'b0, ADDR0} < DEPTH;
        in1 = {1'b0, ADDR1} < DEPTH;
        rd0 = RSTb & ~CSb0 & WEb0;
        rd1 = RSTb & ~CSb1;
        wr0 = RSTb & ~CSb0 & ~WEb0;
        rdata0 = '0;
        rdata1 = '0;
        if (in0) rdata0 = mem_q[ADDR0];
        if (in1) rdata1 = mem_q[ADDR1];
        col = wr0 & rd1 & in0 & (ADDR0 == ADDR1);
        bitmask = '1;
`ifdef SRAM_WMASK_EN
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            bitmask[b*8 +: 8] = {8{WMASK0[b]}};
        end
`endif
        wdata = (rdata0 & ~bitmask) | (DIN0 & bitmask);
    end

    // Array is never reset; out-of-range writes fall through.
    always_ff @(posedge clk) begin
        if (wr0 && in0) begin
            mem_q[ADDR0] <= wdata;
        end
    end

    logic [L-1:0]          v0_q, v0_d, v1_q, v1_d, c1_q, c1_d;
    logic [DATA_WIDTH-1:0] d0_q [L];
    logic [DATA_WIDTH-1:0] d0_d [L];
    logic [DATA_WIDTH-1:0] d1_q [L];
    logic [DATA_WIDTH-1:0] d1_d [L];

    always_comb begin
        v0_d = '0;
        v1_d = '0;
        c1_d = '0;
        d0_d = d0_q;
        d1_d = d1_q;
        v0_d[0] = rd0;
        v1_d[0] = rd1;
        c1_d[0] = col;
        if (rd0) d0_d[0] = rdata0;
        if (rd1) d1_d[0] = rdata1;
        // Data only advances with a valid so the output holds between reads.
        for (int i = 1; i < L; i++) begin
            v0_d[i] = v0_q[i-1];
            v1_d[i] = v1_q[i-1];
            c1_d[i] = c1_q[i-1];
            if (v0_q[i-1]) d0_d[i] = d0_q[i-1];
            if (v1_q[i-1]) d1_d[i] = d1_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            v0_q <= '0;
            v1_q <= '0;
            c1_q <= '0;
            for (int i = 0; i < L; i++) begin
                d0_q[i] <= '0;
                d1_q[i] <= '0;
            end
        end else begin
            v0_q <= v0_d;
            v1_q <= v1_d;
            c1_q <= c1_d;
            d0_q <= d0_d;
            d1_q <= d1_d;
        end
    end

    assign DOUT0     = d0_q[L-1];
    assign VALID0    = v0_q[L-1];
    assign DOUT1     = d1_q[L-1];
    assign VALID1    = v1_q[L-1];
    assign COLLISION = c1_q[L-1];

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Bench for sram_1rw1r_param: latency-1 and latency-2 instances share stimulus.
// Directed vector table, hand sequences and random traffic against a history-based model.
module tb_sram_1rw1r_param;
    localparam int DW    = 32;
    localparam int AW    = 8;
    localparam int DEPTH = 240;
    localparam int NE    = 4096;
    localparam int NV    = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rstb, csb0, web0, csb1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   din0;
    logic [DW/8-1:0] wm;
    logic [DW-1:0]   dout0_1, dout1_1, dout0_2, dout1_2;
    logic            valid0_1, valid1_1, coll_1;
    logic            valid0_2, valid1_2, coll_2;

    sram_1rw1r_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(1)
    ) u_l1 (
        .clk(clk), .RSTb(rstb), .CSb0(csb0), .WEb0(web0),
        .ADDR0(addr0), .DIN0(din0),
`ifdef SRAM_WMASK_EN
        .WMASK0(wm),
`endif
        .DOUT0(dout0_1), .VALID0(valid0_1),
        .CSb1(csb1), .ADDR1(addr1),
        .DOUT1(dout1_1), .VALID1(valid1_1), .COLLISION(coll_1)
    );

    sram_1rw1r_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .READ_LATENCY(2)
    ) u_l2 (
        .clk(clk), .RSTb(rstb), .CSb0(csb0), .WEb0(web0),
        .ADDR0(addr0), .DIN0(din0),
`ifdef SRAM_WMASK_EN
        .WMASK0(wm),
`endif
        .DOUT0(dout0_2), .VALID0(valid0_2),
        .CSb1(csb1), .ADDR1(addr1),
        .DOUT1(dout1_2), .VALID1(valid1_2), .COLLISION(coll_2)
    );

    int checks = 0;
    int failures = 0;

    // Reference: array image plus a per-edge history of requests and read results.
    logic [DW-1:0] ref_mem [256];
    bit            h_rst [NE];
    bit            h_rq0 [NE];
    bit            h_rq1 [NE];
    bit            h_col [NE];
    logic [DW-1:0] h_d0  [NE];
    logic [DW-1:0] h_d1  [NE];
    int            e = 0;
    bit            ev0 [1:2];
    bit            ev1 [1:2];
    bit            ec  [1:2];
    logic [DW-1:0] ed0 [1:2];
    logic [DW-1:0] ed1 [1:2];

    typedef struct {
        logic          rstb;
        logic          csb0;
        logic          web0;
        logic [AW-1:0] a0;
        logic [DW-1:0] din;
        logic          csb1;
        logic [AW-1:0] a1;
        logic          v0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [DW-1:0] d1;
        logic          col;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < DW / 8; b++) begin
            if (wm[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] sw(input int i);
        return 32'hA500_0000 + DW'(i) * 32'h0101;
    endfunction

    task automatic drive(input logic r, input logic c0, input logic w0,
                         input logic [AW-1:0] a0, input logic [DW-1:0] d,
                         input logic c1, input logic [AW-1:0] a1);
        rstb = r; csb0 = c0; web0 = w0; addr0 = a0;
        din0 = d; csb1 = c1; addr1 = a1; wm = '1;
    endtask

    // One clock: record the edge in the history, derive expected outputs, compare.
    task automatic tick();
        bit ok;
        int k;
        @(posedge clk);
        h_rst[e] = !rstb;
        h_rq0[e] = rstb && !csb0 && web0;
        h_rq1[e] = rstb && !csb1;
        h_d0[e]  = rd_ref(addr0);
        h_d1[e]  = rd_ref(addr1);
        h_col[e] = rstb && !csb0 && !web0 && !csb1 &&
                   addr0 == addr1 && int'(addr0) < DEPTH;
        if (rstb && !csb0 && !web0 && int'(addr0) < DEPTH)
            ref_mem[addr0] = merge(ref_mem[addr0], din0);
        for (int lat = 1; lat <= 2; lat++) begin
            k  = e - lat + 1;
            ok = !h_rst[e] && k >= 0;
            for (int j = k; j <= e && ok; j++) begin
                if (h_rst[j]) ok = 1'b0;
            end
            ev0[lat] = 1'b0;
            ev1[lat] = 1'b0;
            ec[lat]  = 1'b0;
            if (h_rst[e]) begin
                ed0[lat] = '0;
                ed1[lat] = '0;
            end else if (ok) begin
                ev0[lat] = h_rq0[k];
                ev1[lat] = h_rq1[k];
                ec[lat]  = h_rq1[k] && h_col[k];
                if (h_rq0[k]) ed0[lat] = h_d0[k];
                if (h_rq1[k]) ed1[lat] = h_d1[k];
            end
        end
        e++;
        @(negedge clk);
        chk1 ($sformatf("m_l1_valid0@%0d", e), valid0_1, ev0[1]);
        chk32($sformatf("m_l1_dout0@%0d", e),  dout0_1,  ed0[1]);
        chk1 ($sformatf("m_l1_valid1@%0d", e), valid1_1, ev1[1]);
        chk32($sformatf("m_l1_dout1@%0d", e),  dout1_1,  ed1[1]);
        chk1 ($sformatf("m_l1_coll@%0d", e),   coll_1,   ec[1]);
        chk1 ($sformatf("m_l2_valid0@%0d", e), valid0_2, ev0[2]);
        chk32($sformatf("m_l2_dout0@%0d", e),  dout0_2,  ed0[2]);
        chk1 ($sformatf("m_l2_valid1@%0d", e), valid1_2, ev1[2]);
        chk32($sformatf("m_l2_dout1@%0d", e),  dout1_2,  ed1[2]);
        chk1 ($sformatf("m_l2_coll@%0d", e),   coll_2,   ec[2]);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        for (int i = 1; i <= 2; i++) begin
            ev0[i] = 1'b0; ev1[i] = 1'b0; ec[i] = 1'b0;
            ed0[i] = '0;   ed1[i] = '0;
        end

        // Expectations are for the latency-1 instance, after the row's edge.
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 8'h05,
                    1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 8'h05,
                    1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b1, 8'h00,
                    1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 8'h00,
                    1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 8'h10,
                    1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h11111111, 1'b1, 8'h00,
                    1'b0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h22222222, 1'b0, 8'h20,
                    1'b0, 32'hDEADBEEF, 1'b1, 32'h11111111, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, 8'h20,
                    1'b0, 32'hDEADBEEF, 1'b1, 32'h22222222, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h20, 32'h0, 1'b1, 8'h00,
                    1'b1, 32'h22222222, 1'b0, 32'h22222222, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'hF0, 32'hCAFEF00D, 1'b1, 8'h00,
                    1'b0, 32'h22222222, 1'b0, 32'h22222222, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 8'hF0, 32'h0, 1'b0, 8'hF5,
                    1'b1, 32'h0, 1'b1, 32'h0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rstb, tbl[i].csb0, tbl[i].web0, tbl[i].a0,
                  tbl[i].din, tbl[i].csb1, tbl[i].a1);
            tick();
            chk1 ($sformatf("tbl%0d_valid0", i), valid0_1, tbl[i].v0);
            chk32($sformatf("tbl%0d_dout0", i),  dout0_1,  tbl[i].d0);
            chk1 ($sformatf("tbl%0d_valid1", i), valid1_1, tbl[i].v1);
            chk32($sformatf("tbl%0d_dout1", i),  dout1_1,  tbl[i].d1);
            chk1 ($sformatf("tbl%0d_coll", i),   coll_1,   tbl[i].col);
        end

        // Fill 0..15, then stream port 1 over 0..7 and watch the hold.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 1'b0, AW'(i), sw(i), 1'b1, 8'h00);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b0, AW'(i));
            tick();
            chk1 ($sformatf("stream%0d_valid1", i), valid1_1, 1'b1);
            chk32($sformatf("stream%0d_dout1", i),  dout1_1,  sw(i));
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b1, 8'h00);
            tick();
            chk1 ($sformatf("hold%0d_valid1", i), valid1_1, 1'b0);
            chk32($sformatf("hold%0d_dout1", i),  dout1_1,  sw(7));
        end

`ifdef SRAM_WMASK_EN
        drive(1'b1, 1'b0, 1'b0, 8'h30, 32'hAABBCCDD, 1'b1, 8'h00);
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h30, 32'h11223344, 1'b1, 8'h00);
        wm = 4'b0101;
        tick();
        drive(1'b1, 1'b0, 1'b0, 8'h30, 32'hFFFFFFFF, 1'b1, 8'h00);
        wm = 4'b0000;
        tick();
        drive(1'b1, 1'b0, 1'b1, 8'h30, 32'h0, 1'b0, 8'h30);
        tick();
        chk32("wmask_dout0", dout0_1, 32'hAA22CC44);
        chk32("wmask_dout1", dout1_1, 32'hAA22CC44);
`endif

        // Read in flight on the latency-2 instance is killed by reset.
        drive(1'b1, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 8'h10);
        tick();
        chk1("flight_l2_valid0_pre", valid0_2, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h00, 32'h0, 1'b1, 8'h00);
        tick();
        chk1 ("flight_l2_valid0_rst", valid0_2, 1'b0);
        chk1 ("flight_l2_valid1_rst", valid1_2, 1'b0);
        chk32("flight_l2_dout0_rst",  dout0_2,  32'h0);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b1, 8'h00);
        tick();
        chk1("flight_l2_valid0_post", valid0_2, 1'b0);
        chk1("flight_l2_valid1_post", valid1_2, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0, 8'h10);
        tick();
        chk1("retain_l2_valid0_early", valid0_2, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h00, 32'h0, 1'b1, 8'h00);
        tick();
        chk1 ("retain_l2_valid0", valid0_2, 1'b1);
        chk32("retain_l2_dout0",  dout0_2,  32'hDEADBEEF);
        chk1 ("retain_l2_valid1", valid1_2, 1'b1);
        chk32("retain_l2_dout1",  dout1_2,  32'hDEADBEEF);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] a0, a1;
            a0 = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(240, 255))
                                             : AW'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 2) == 0) ? a0
                                             : AW'($urandom_range(0, 15));
            drive(1'($urandom_range(0, 39) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  a0, $urandom(), 1'($urandom_range(0, 1)), a1);
`ifdef SRAM_WMASK_EN
            wm = (DW/8)'($urandom());
`endif
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
